fright_mode_ctrl: RTL and testbench
===================================

Name: fright_mode_ctrl

Overview:
Consumes the power-pellet event (ate_pellet) and level-clear (new_map) from the points/pellet stage. Runs the ghost frightened-mode timer and end-of-fright flash. Scores ghost captures with the doubling combo (200/400/800/1600) for the score adder and ghost FSMs downstream. Single Clk domain; frame timing comes from frame_clk, synchronised and edge-detected internally.

Parameters:
FRIGHT_FRAMES, 360, total frightened duration in frames (≤1023)
FLASH_FRAMES, 120, final frames of fright during which flash runs (<FRIGHT_FRAMES)
FLASH_PERIOD, 8, frames per flash half-period (≥1)
NUM_GHOSTS, 4, number of ghosts (1..4)
BASE_BONUS, 200, first capture bonus

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-low reset
frame_clk  in  1  frame-rate strobe, asynchronous to Clk; a rising edge marks one frame
ate_pellet  in  1  level from points stage; a rising edge means a power pellet was eaten
new_map  in  1  level; high means the level was cleared
hard_reset  in  1  synchronous game restart, active-high
ghost_caught  in  NUM_GHOSTS  bit i high while Pac-Man overlaps ghost i
ghost_home  in  NUM_GHOSTS  1-cycle pulse; ghost i has reached the house
frightened  out  1  FSM is in FRIGHT or FLASH
flash  out  1  ghost sprite alternate colour select
fright_mask  out  NUM_GHOSTS  ghost i is frightened: frightened & ~eaten[i]
ghost_eaten  out  NUM_GHOSTS  ghost i is eaten, eyes returning home
bonus_valid  out  1  1-cycle capture pulse
bonus_points  out  12  capture value; valid only when bonus_valid=1
frames_left  out  10  remaining fright frames
bonus_total  out  20  cumulative capture score (see Optional Feature)

Behaviour:
- Reset low: all outputs and all state are 0; the FSM is IDLE. Reset assertion is immediate; release is synchronous to Clk.
- frame_clk: 2-flop synchroniser, then rising-edge detect, giving frame_tick (1 Clk). frame_tick lags the frame_clk edge by 3 Clk cycles.
- ate_pellet: registered, then rising-edge detect, giving pel_ev. A held level produces exactly one event.
- FSM states IDLE, FRIGHT, FLASH. Priority within each cycle is clear > pel_ev > capture > frame_tick.
  - clear (hard_reset | new_map): go to IDLE. frames_left, combo, ghost_eaten, flash and bonus_valid are all set to 0. bonus_total is unaffected by new_map and is zeroed by hard_reset.
  - pel_ev, from any state: go to FRIGHT. frames_left=FRIGHT_FRAMES, combo=0, flash=0, flash counter=0. ghost_eaten is unchanged. A frame_tick or capture in the same cycle is ignored.
  - FRIGHT, on frame_tick: frames_left is decremented. If the new value equals FLASH_FRAMES, go to FLASH with flash=1 and flash counter=0.
  - FLASH, on frame_tick: frames_left is decremented. The flash counter increments; when it reaches FLASH_PERIOD it wraps to 0 and flash toggles. If the new frames_left is 0, go to IDLE with flash=0 and combo=0.
- Capture, evaluated only in FRIGHT/FLASH: hits = ghost_caught & fright_mask. Only the lowest set index is taken per cycle.
  - The taken ghost gets eaten[i]=1, plus bonus_valid=1 and bonus_points=BASE_BONUS<<combo on the next cycle.
  - combo increments, saturating at 3, so a fifth or later capture in the same fright pays 1600.
  - Remaining hits are serviced on later cycles while still caught.
- A capture coinciding with a frame_tick that ends fright (frames_left 1→0) is still scored; the combo clear applies after it.
- ghost_home[i] clears eaten[i] in any state. A simultaneous capture of the same ghost cannot occur, because a ghost whose eaten[i]=1 has fright_mask[i]=0.
- In IDLE: fright_mask=0 and ghost_caught is ignored. ghost_eaten persists across IDLE until ghost_home.
- Latency: pel_ev to frightened=1 is 1 Clk. Capture to bonus_valid is 1 Clk.

Optional Feature:
FRIGHT_SCORE_ACC_EN
- Defined: bonus_total accumulates bonus_points on every bonus_valid, saturating at 20'hFFFFF; it is zeroed by Reset or hard_reset.
- Undefined: no accumulator logic; bonus_total is constant 0.

Test Plan:
- Reset low mid-FRIGHT → all outputs 0 immediately; after release, a pellet edge → frightened=1 and frames_left=360 one cycle later.
- Pellet edge followed by 240 frame ticks → flash=1 and frames_left=120; flash toggles every 8 ticks; after 120 more ticks frightened=0, flash=0, IDLE.
- Four captures of ghosts 0..3 on separate cycles → bonus_points 200, 400, 800, 1600; fright_mask ends 0; ghost_home[2] → ghost_eaten[2]=0.
- ghost_caught=4'b1010 in one cycle → ghost 1 scores 200, then next cycle ghost 3 scores 400; exactly two bonus_valid pulses.
- Second pellet edge at frames_left=50 with combo=2 → frames_left=360, combo=0, next capture pays 200; ate_pellet held 100 cycles → single reload.
- new_map during FLASH → IDLE, frames_left=0, ghost_eaten=0, bonus_total retained (macro on); hard_reset → bonus_total=0.

Source files
------------

// File: rtl/fright_mode_ctrl_if.sv
// Bundle between the pellet/points stage, the ghost FSMs, the score adder and
// fright_mode_ctrl. The master side drives the game events; the slave side
// (fright_mode_ctrl) drives the fright status and the capture bonus.
interface fright_mode_ctrl_if #(
  parameter int NUM_GHOSTS = 4
) ();
  logic                  ate_pellet;
  logic                  new_map;
  logic                  hard_reset;
  logic [NUM_GHOSTS-1:0] ghost_caught;
  logic [NUM_GHOSTS-1:0] ghost_home;
  logic                  frightened;
  logic                  flash;
  logic [NUM_GHOSTS-1:0] fright_mask;
  logic [NUM_GHOSTS-1:0] ghost_eaten;
  logic                  bonus_valid;
  logic [11:0]           bonus_points;
  logic [9:0]            frames_left;
  logic [19:0]           bonus_total;

  modport master (
    output ate_pellet, new_map, hard_reset, ghost_caught, ghost_home,
    input  frightened, flash, fright_mask, ghost_eaten, bonus_valid,
           bonus_points, frames_left, bonus_total
  );

  modport slave (
    input  ate_pellet, new_map, hard_reset, ghost_caught, ghost_home,
    output frightened, flash, fright_mask, ghost_eaten, bonus_valid,
           bonus_points, frames_left, bonus_total
  );
endinterface

// File: rtl/fright_mode_ctrl.sv
// Ghost frightened-mode controller: fright timer, end-of-fright flash and
// doubling capture bonus (200/400/800/1600, saturating).
// Optional macro FRIGHT_SCORE_ACC_EN: when defined, bonus_total accumulates
// every paid bonus (saturating); otherwise bonus_total is tied to 0.
module fright_mode_ctrl #(
  parameter int FRIGHT_FRAMES = 360,
  parameter int FLASH_FRAMES  = 120,
  parameter int FLASH_PERIOD  = 8,
  parameter int NUM_GHOSTS    = 4,
  parameter int BASE_BONUS    = 200
) (
  input logic               Clk,
  input logic               Reset,
  input logic               frame_clk,
  fright_mode_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FRIGHT, FLASH} state_t;

  state_t                state_q, state_d;
  logic [2:0]            fc_sync;
  logic                  frame_tick;
  logic [1:0]            ap_sync;
  logic                  pel_ev, clear, active;
  logic [NUM_GHOSTS-1:0] eaten_q, mask, hits, pick;
  logic                  cap, tick_live, enter_flash, end_fright, fc_wrap;
  logic [9:0]            frames_q, dec, fcnt_q, fcnt_inc;
  logic [1:0]            combo_q;
  logic                  flash_q, bvalid_q;
  logic [11:0]           bpoints_q;

  // frame_clk crosses into Clk through two flops; the third flop gives the
  // edge, and the tick is registered so it is one clean Clk pulse.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fc_sync    <= '0;
      frame_tick <= 1'b0;
    end else begin
      fc_sync    <= {fc_sync[1:0], frame_clk};
      frame_tick <= fc_sync[1] & ~fc_sync[2];
    end
  end

  // ate_pellet is a level; only its rising edge reloads fright.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) ap_sync <= '0;
    else        ap_sync <= {ap_sync[0], bus.ate_pellet};
  end

  assign pel_ev   = ap_sync[0] & ~ap_sync[1];
  assign clear    = bus.hard_reset | bus.new_map;
  assign active   = (state_q != IDLE);
  assign mask     = active ? ~eaten_q : '0;
  assign hits     = bus.ghost_caught & mask;
  // Isolate the lowest set hit; the rest wait for later cycles.
  assign pick     = hits & (~hits + NUM_GHOSTS'(1));
  assign cap      = (|hits) & ~clear & ~pel_ev;
  assign dec      = frames_q - 10'd1;
  assign tick_live   = frame_tick & ~clear & ~pel_ev & active;
  assign enter_flash = tick_live & (state_q == FRIGHT) & (dec == 10'(FLASH_FRAMES));
  assign end_fright  = tick_live & (state_q == FLASH) & (dec == 10'd0);
  assign fcnt_inc    = fcnt_q + 10'd1;
  assign fc_wrap     = (fcnt_inc == 10'(FLASH_PERIOD));

  // FSM state register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: clear > pellet > timer transitions.
  always_comb begin
    state_d = state_q;
    if (clear)            state_d = IDLE;
    else if (pel_ev)      state_d = FRIGHT;
    else if (enter_flash) state_d = FLASH;
    else if (end_fright)  state_d = IDLE;
  end

  // FSM outputs.
  always_comb begin
    bus.frightened  = active;
    bus.fright_mask = mask;
  end

  // Timer, flash, combo, eaten set and bonus pulse. Later assignments
  // override earlier ones, which encodes the per-cycle priority; a capture on
  // the tick that ends fright is still paid, then the combo clears.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      frames_q  <= '0;
      fcnt_q    <= '0;
      combo_q   <= '0;
      flash_q   <= 1'b0;
      eaten_q   <= '0;
      bvalid_q  <= 1'b0;
      bpoints_q <= '0;
    end else begin
      bvalid_q  <= cap;
      bpoints_q <= cap ? (12'(BASE_BONUS) << combo_q) : 12'd0;
      eaten_q   <= (eaten_q & ~bus.ghost_home) | (cap ? pick : '0);
      if (cap) combo_q <= (combo_q == 2'd3) ? 2'd3 : combo_q + 2'd1;
      if (clear) begin
        frames_q <= '0;
        combo_q  <= '0;
        eaten_q  <= '0;
        flash_q  <= 1'b0;
        fcnt_q   <= '0;
      end else if (pel_ev) begin
        frames_q <= 10'(FRIGHT_FRAMES);
        combo_q  <= '0;
        flash_q  <= 1'b0;
        fcnt_q   <= '0;
      end else if (tick_live) begin
        frames_q <= dec;
        if (state_q == FRIGHT) begin
          if (enter_flash) begin
            flash_q <= 1'b1;
            fcnt_q  <= '0;
          end
        end else begin
          fcnt_q <= fc_wrap ? 10'd0 : fcnt_inc;
          if (fc_wrap) flash_q <= ~flash_q;
          if (end_fright) begin
            flash_q <= 1'b0;
            combo_q <= '0;
          end
        end
      end
    end
  end

  assign bus.flash        = flash_q;
  assign bus.ghost_eaten  = eaten_q;
  assign bus.bonus_valid  = bvalid_q;
  assign bus.bonus_points = bpoints_q;
  assign bus.frames_left  = frames_q;

`ifdef FRIGHT_SCORE_ACC_EN
  logic [19:0] total_q;
  logic [20:0] acc_sum;
  assign acc_sum = {1'b0, total_q} + 21'(bpoints_q);

  // Running capture score, saturating; new_map leaves it alone.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)              total_q <= '0;
    else if (bus.hard_reset) total_q <= '0;
    else if (bvalid_q)       total_q <= acc_sum[20] ? 20'hFFFFF : acc_sum[19:0];
  end
  assign bus.bonus_total = total_q;
`else
  assign bus.bonus_total = 20'd0;
`endif
endmodule

// File: tb/tb_fright_mode_ctrl.sv
// Bench for fright_mode_ctrl: directed scenarios plus a random phase against a
// frame-count model; bonus pulses are checked by a scoreboard monitor.
module tb_fright_mode_ctrl;
  localparam int FRIGHT = 360;
  localparam int FLASHF = 120;
  localparam int PERIOD = 8;
`ifdef FRIGHT_SCORE_ACC_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  typedef struct { int pts; int tot; } exp_t;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic frame_clk = 1'b0;
  fright_mode_ctrl_if #(.NUM_GHOSTS(4)) bus();

  fright_mode_ctrl dut (.Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .bus(bus));

  always #5 Clk = ~Clk;

  int   n_chk = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  // Reference model: remaining frames, eaten set, captures this fright, score.
  int       m_frames = 0;
  logic [3:0] m_eaten = '0;
  int       m_combo = 0;
  int       m_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_flash(input int f);
    if (f == 0 || f > FLASHF) return 0;
    return (((FLASHF - f) / PERIOD) % 2 == 0) ? 1 : 0;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic chk_state(input string tag);
    logic [3:0] em;
    em = (m_frames != 0) ? ~m_eaten : 4'b0;
    chk({tag, ".frightened"}, int'(bus.frightened), int'(m_frames != 0));
    chk({tag, ".frames_left"}, int'(bus.frames_left), m_frames);
    chk({tag, ".flash"}, int'(bus.flash), exp_flash(m_frames));
    chk({tag, ".fright_mask"}, int'(bus.fright_mask), int'(em));
    chk({tag, ".ghost_eaten"}, int'(bus.ghost_eaten), int'(m_eaten));
    chk({tag, ".bonus_total"}, int'(bus.bonus_total), ACC ? m_total : 0);
  endtask

  task automatic frame();
    frame_clk = 1'b1; step(4);
    frame_clk = 1'b0; step(4);
    if (m_frames > 0) m_frames--;
    if (m_frames == 0) m_combo = 0;
  endtask

  task automatic pellet();
    bus.ate_pellet = 1'b1; step(2);
    bus.ate_pellet = 1'b0; step(2);
    m_frames = FRIGHT; m_combo = 0;
  endtask

  // Expected payouts are queued in ascending ghost order before driving.
  task automatic capture(input logic [3:0] cm);
    int n = 0;
    for (int i = 0; i < 4; i++) begin
      if (cm[i] && !m_eaten[i] && m_frames != 0) begin
        exp_t e;
        e.pts = 200 << ((m_combo > 3) ? 3 : m_combo);
        e.tot = m_total;
        exp_q.push_back(e);
        m_total = (m_total + e.pts > 20'hFFFFF) ? 20'hFFFFF : m_total + e.pts;
        m_combo++;
        m_eaten[i] = 1'b1;
        n++;
      end
    end
    bus.ghost_caught = cm; step(n + 2);
    bus.ghost_caught = '0; step(2);
    chk("sb_drain", exp_q.size(), 0);
  endtask

  task automatic home(input logic [3:0] hm);
    bus.ghost_home = hm; step(1);
    bus.ghost_home = '0; step(1);
    m_eaten &= ~hm;
  endtask

  task automatic clear_pulse(input bit hard);
    if (hard) bus.hard_reset = 1'b1; else bus.new_map = 1'b1;
    step(1);
    bus.hard_reset = 1'b0; bus.new_map = 1'b0; step(2);
    m_frames = 0; m_combo = 0; m_eaten = '0;
    if (hard) m_total = 0;
  endtask

  // Scoreboard monitor: every bonus pulse must match the oldest expectation.
  always @(negedge Clk) begin
    if (Reset && bus.bonus_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_bad++;
        $display("FAIL unexpected_bonus: got %0d expected none at %0t", bus.bonus_points, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("bonus_points", int'(bus.bonus_points), e.pts);
        chk("bonus_total_pre", int'(bus.bonus_total), ACC ? e.tot : 0);
      end
    end
  end

  initial begin
    bus.ate_pellet = 1'b0; bus.new_map = 1'b0; bus.hard_reset = 1'b0;
    bus.ghost_caught = '0; bus.ghost_home = '0;
    step(3);
    chk_state("reset");
    chk("reset.bonus_valid", int'(bus.bonus_valid), 0);
    chk("reset.bonus_points", int'(bus.bonus_points), 0);
    Reset = 1'b1; step(2);

    // Reset asserted mid-fright clears everything immediately.
    pellet();
    chk_state("pellet1");
    repeat (5) frame();
    bus.ghost_home = 4'b0000;
    @(posedge Clk); #3;
    Reset = 1'b0; #1;
    m_frames = 0; m_combo = 0; m_eaten = '0; m_total = 0;
    chk_state("async_reset");
    step(2); Reset = 1'b1; step(2);
    pellet();
    chk_state("pellet_after_reset");

    // Full fright run through the flash window.
    repeat (240) frame();
    chk_state("flash_entry");
    for (int k = 0; k < 120; k++) begin
      frame();
      chk_state("flash_run");
    end

    // Four separate captures, then a fifth that stays at the cap.
    pellet();
    for (int g = 0; g < 4; g++) capture(4'(1 << g));
    chk_state("all_eaten");
    home(4'b0100);
    chk_state("home2");
    capture(4'b0100);

    // Reload leaves eaten untouched; two simultaneous hits serialize.
    pellet();
    chk_state("reload_eaten_kept");
    home(4'b1111);
    capture(4'b1010);
    chk_state("two_hits");

    repeat (310) frame();
    chk_state("at50");
    bus.ate_pellet = 1'b1; step(2);
    m_frames = FRIGHT; m_combo = 0;
    chk_state("reload50");
    repeat (3) frame();
    step(70);
    chk_state("held_pellet");
    bus.ate_pellet = 1'b0; step(2);
    home(4'b1010);
    capture(4'b0001);

    // Random mix of game events.
    for (int it = 0; it < 250; it++) begin
      int a;
      a = $urandom_range(0, 99);
      if (a < 40)      frame();
      else if (a < 65) capture(4'($urandom_range(0, 15)));
      else if (a < 80) home(4'($urandom_range(0, 15)));
      else if (a < 94) pellet();
      else if (a < 97) clear_pulse(1'b0);
      else             clear_pulse(1'b1);
      chk_state("random");
    end

    // Level clear during flash keeps the score; hard reset zeroes it.
    clear_pulse(1'b1);
    pellet();
    capture(4'b0011);
    repeat (245) frame();
    chk_state("pre_newmap");
    clear_pulse(1'b0);
    chk_state("new_map");
    clear_pulse(1'b1);
    chk_state("hard_reset");

    step(3);
    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
